// File: rtl/tcp_flowid_alloc_arb_if.sv
// Allocation/free bus of the TCP flow ID pool.
// The master is the requester/teardown side; the slave is the pool arbiter.
interface tcp_flowid_alloc_arb_if #(
   parameter int FLOWID_W = 6,
   parameter int NUM_REQ  = 2
);
   logic [NUM_REQ-1:0]  alloc_req;
   logic [NUM_REQ-1:0]  alloc_grant;
   logic                alloc_avail;
   logic [FLOWID_W-1:0] alloc_flowid;
   logic                free_val;
   logic [FLOWID_W-1:0] free_flowid;
   logic                free_rdy;
   logic                free_overflow;
   logic [FLOWID_W:0]   num_free;
   logic                init_done;

   modport master (
      output alloc_req, free_val, free_flowid,
      input  alloc_grant, alloc_avail, alloc_flowid, free_rdy, free_overflow,
             num_free, init_done
   );

   modport slave (
      input  alloc_req, free_val, free_flowid,
      output alloc_grant, alloc_avail, alloc_flowid, free_rdy, free_overflow,
             num_free, init_done
   );
endinterface

// File: rtl/tcp_flowid_alloc_arb.sv
// TCP flow ID pool: circular free-list of IDs, round-robin allocation between
// NUM_REQ requesters, frees from connection teardown. After reset the list is
// filled with IDs 0..NUM_FLOWS-1, one per cycle, before any grant is issued.
module tcp_flowid_alloc_arb #(
   parameter int FLOWID_W  = 6,
   parameter int NUM_FLOWS = 2**FLOWID_W,
   parameter int NUM_REQ   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   tcp_flowid_alloc_arb_if.slave bus
);
   localparam int                RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [FLOWID_W:0] POOL_FULL = (FLOWID_W + 1)'(NUM_FLOWS);
   localparam logic [FLOWID_W-1:0] LAST_ID = FLOWID_W'(NUM_FLOWS - 1);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t state_q, state_d;

   // NOTE: the free-list storage has no reset; the INIT sweep writes every
   // entry before the first read, so resetting it would only cost flops.
   logic [FLOWID_W-1:0] mem [NUM_FLOWS];

   logic [FLOWID_W-1:0] head_q, tail_q;
   logic [FLOWID_W:0]   num_free_q;
   logic [RR_W-1:0]     rr_ptr_q;
   logic [NUM_REQ-1:0]  grant_q;
   logic                avail_q;
   logic [FLOWID_W-1:0] flowid_q;
   logic                overflow_q;
   logic                init_done_q;

   logic [NUM_REQ-1:0]  eff_req;
   logic                pick_vld;
   logic [RR_W-1:0]     pick_idx;
   logic [RR_W-1:0]     rr_next;
   logic [NUM_REQ-1:0]  grant_d;
   int unsigned         idx;

   logic init_wr;
   logic free_rdy_c;
   logic free_acc;
   logic grant_en;
   logic alloc_take;

   // Round-robin pick from rr_ptr, masking last cycle's grantee (it may not
   // have dropped its request yet).
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment,
      // so no path leaves a value unassigned and no latch is inferred.
      eff_req  = bus.alloc_req & ~grant_q;
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = 0;
      grant_d  = '0;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (eff_req[idx]) begin
            pick_vld = 1'b1;
            pick_idx = idx[RR_W-1:0];
         end
      end
      grant_d[pick_idx] = pick_vld;
      rr_next = RR_W'((int'(pick_idx) + 1) % NUM_REQ);
   end

   // FSM next state and per-cycle pool strobes.
   always_comb begin
      state_d    = state_q;
      init_wr    = 1'b0;
      free_rdy_c = 1'b0;
      free_acc   = 1'b0;
      grant_en   = 1'b0;
      alloc_take = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_wr = 1'b1;
            if (tail_q == LAST_ID) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            free_rdy_c = (num_free_q != POOL_FULL);
            free_acc   = bus.free_val & free_rdy_c;
            grant_en   = pick_vld;
            // An empty pool still answers, but with avail=0 and no pop; a
            // same-cycle free is not bypassed to the allocator.
            alloc_take = pick_vld & (num_free_q != '0);
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: all clocked state uses non-blocking assignments so every
      // register samples the pre-edge values of its peers.
      if (rst) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Free-list write port: the INIT sweep or an accepted free, at the tail.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (init_wr) begin
            mem[tail_q] <= tail_q;
         end else if (free_acc) begin
            mem[tail_q] <= bus.free_flowid;
         end
      end
   end

   // Pointers, occupancy, registered grant response and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         num_free_q  <= '0;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         avail_q     <= 1'b0;
         flowid_q    <= '0;
         overflow_q  <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         if (init_wr || free_acc) begin
            tail_q <= tail_q + 1'b1;
         end
         if (alloc_take) begin
            head_q <= head_q + 1'b1;
         end
         // Push and pop in the same cycle cancel out.
         case ({init_wr | free_acc, alloc_take})
            2'b10:   num_free_q <= num_free_q + 1'b1;
            2'b01:   num_free_q <= num_free_q - 1'b1;
            default: num_free_q <= num_free_q;
         endcase
         grant_q <= grant_en ? grant_d : '0;
         avail_q <= alloc_take;
         if (grant_en) begin
            flowid_q <= alloc_take ? mem[head_q] : '0;
            rr_ptr_q <= rr_next;
         end
         // A free offered while the pool is full means a double free upstream.
         if (state_q == ST_RUN && bus.free_val && !free_rdy_c) begin
            overflow_q <= 1'b1;
         end
         init_done_q <= (state_d == ST_RUN);
      end
   end

   assign bus.alloc_grant   = grant_q;
   assign bus.alloc_avail   = avail_q;
   assign bus.alloc_flowid  = flowid_q;
   assign bus.free_rdy      = free_rdy_c;
   assign bus.free_overflow = overflow_q;
   assign bus.num_free      = num_free_q;
   assign bus.init_done     = init_done_q;
endmodule

// File: tb/tb_tcp_flowid_alloc_arb.sv
// Bench for the TCP flow ID pool: a queue-based pool model checked every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_tcp_flowid_alloc_arb;
   localparam int FLOWID_W  = 6;
   localparam int NUM_FLOWS = 64;
   localparam int NUM_REQ   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tcp_flowid_alloc_arb_if #(.FLOWID_W(FLOWID_W), .NUM_REQ(NUM_REQ)) bus ();

   tcp_flowid_alloc_arb #(
      .FLOWID_W (FLOWID_W),
      .NUM_FLOWS(NUM_FLOWS),
      .NUM_REQ  (NUM_REQ)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- pool model ----------------
   int                 m_q[$];        // free IDs in allocation order
   int                 m_init_cnt = 0;
   int                 m_rr = 0;
   logic [NUM_REQ-1:0] m_last = '0;
   logic [NUM_REQ-1:0] e_grant = '0;
   logic               e_avail = 1'b0;
   int                 e_flowid = 0;
   logic               e_ovf = 1'b0;
   bit                 m_started = 1'b0;
   logic [NUM_REQ-1:0] m_want;
   int                 m_winner;
   bit                 m_room;

   always @(posedge clk) begin
      m_started = 1'b1;
      if (rst) begin
         m_q.delete();
         m_init_cnt = 0;
         m_rr       = 0;
         m_last     = '0;
         e_grant    = '0;
         e_avail    = 1'b0;
         e_flowid   = 0;
         e_ovf      = 1'b0;
      end else if (m_init_cnt < NUM_FLOWS) begin
         m_q.push_back(m_init_cnt);
         m_init_cnt++;
         e_grant = '0;
         e_avail = 1'b0;
      end else begin
         m_want   = bus.alloc_req & ~m_last;
         m_winner = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (m_winner < 0 && m_want[(m_rr + k) % NUM_REQ]) m_winner = (m_rr + k) % NUM_REQ;
         end
         m_room = (m_q.size() != NUM_FLOWS);
         if (bus.free_val && !m_room) e_ovf = 1'b1;
         e_grant = '0;
         e_avail = 1'b0;
         if (m_winner >= 0) begin
            e_grant[m_winner] = 1'b1;
            if (m_q.size() > 0) begin
               e_avail  = 1'b1;
               e_flowid = m_q.pop_front();
            end else begin
               e_flowid = 0;
            end
            m_rr = (m_winner + 1) % NUM_REQ;
         end
         m_last = e_grant;
         if (bus.free_val && m_room) m_q.push_back(int'(bus.free_flowid));
      end
   end

   // Compare DUT against the model on the falling edge of every cycle.
   always @(negedge clk) begin
      if (m_started) begin
         check("grant", 32'(bus.alloc_grant), 32'(e_grant));
         check("avail", 32'(bus.alloc_avail), 32'(e_avail));
         if (e_grant != '0 || m_init_cnt < NUM_FLOWS)
            check("flowid", 32'(bus.alloc_flowid), 32'(e_flowid));
         check("num_free", 32'(bus.num_free), 32'(m_q.size()));
         check("init_done", 32'(bus.init_done), 32'(m_init_cnt == NUM_FLOWS));
         check("free_rdy", 32'(bus.free_rdy),
               32'(m_init_cnt == NUM_FLOWS && m_q.size() != NUM_FLOWS));
         check("free_overflow", 32'(bus.free_overflow), 32'(e_ovf));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(output int cycles);
      rst              = 1'b1;
      bus.alloc_req    = '0;
      bus.free_val     = 1'b0;
      bus.free_flowid  = '0;
      tick();
      tick();
      rst    = 1'b0;
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!bus.init_done && cycles < 200);
   endtask

   task automatic request(input logic [NUM_REQ-1:0] ports, output logic [NUM_REQ-1:0] g,
                          output logic a, output logic [FLOWID_W-1:0] id, output int lat);
      lat = 0;
      bus.alloc_req = ports;
      do begin
         tick();
         lat++;
      end while (bus.alloc_grant == '0 && lat < 20);
      g  = bus.alloc_grant;
      a  = bus.alloc_avail;
      id = bus.alloc_flowid;
      bus.alloc_req = bus.alloc_req & ~bus.alloc_grant;
      check("grant_seen", 32'(g != '0), 32'd1);
   endtask

   task automatic free_id(input int id);
      bus.free_val    = 1'b1;
      bus.free_flowid = FLOWID_W'(id);
      tick();
      bus.free_val    = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int                  cyc;
      int                  lat;
      int                  guard;
      logic [NUM_REQ-1:0]  g;
      logic                a;
      logic [FLOWID_W-1:0] id;

      bus.alloc_req   = '0;
      bus.free_val    = 1'b0;
      bus.free_flowid = '0;

      // 1: init sweep length and full pool
      do_reset(cyc);
      check("t1_init_cycles", 32'(cyc), 32'd64);
      check("t1_num_free", 32'(bus.num_free), 32'd64);

      // 2: single requester, one-cycle response latency, IDs in order
      request(2'b01, g, a, id, lat);
      check("t2_latency", 32'(lat), 32'd1);
      check("t2_grant", 32'(g), 32'd1);
      check("t2_avail", 32'(a), 32'd1);
      check("t2_flowid", 32'(id), 32'd0);
      request(2'b01, g, a, id, lat);
      check("t2_flowid2", 32'(id), 32'd1);
      check("t2_num_free", 32'(bus.num_free), 32'd62);

      // 3: both ports hold requests from a fresh pool -> strict alternation
      do_reset(cyc);
      bus.alloc_req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t3_grant%0d", i), 32'(bus.alloc_grant), (i % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("t3_flowid%0d", i), 32'(bus.alloc_flowid), 32'(i));
      end
      bus.alloc_req = '0;
      tick();
      check("t3_num_free", 32'(bus.num_free), 32'd60);

      // 4: drain, empty answer, free 17 and reallocate it
      guard = 0;
      while (bus.num_free != '0 && guard < 100) begin
         request(2'b01, g, a, id, lat);
         guard++;
      end
      check("t4_drain_count", 32'(guard), 32'd60);
      request(2'b01, g, a, id, lat);
      check("t4_empty_avail", 32'(a), 32'd0);
      check("t4_empty_flowid", 32'(id), 32'd0);
      free_id(17);
      request(2'b01, g, a, id, lat);
      check("t4_avail", 32'(a), 32'd1);
      check("t4_flowid", 32'(id), 32'd17);

      // 5: free and request on an empty pool in the same cycle: no bypass
      bus.free_val    = 1'b1;
      bus.free_flowid = FLOWID_W'(5);
      bus.alloc_req   = 2'b10;
      tick();
      check("t5_grant", 32'(bus.alloc_grant), 32'd2);
      check("t5_avail", 32'(bus.alloc_avail), 32'd0);
      check("t5_flowid", 32'(bus.alloc_flowid), 32'd0);
      bus.free_val  = 1'b0;
      bus.alloc_req = '0;
      request(2'b10, g, a, id, lat);
      check("t5_avail2", 32'(a), 32'd1);
      check("t5_flowid2", 32'(id), 32'd5);
      check("t5_num_free", 32'(bus.num_free), 32'd0);

      // 6: free into a full pool, sticky overflow, reset mid-drain
      do_reset(cyc);
      check("t6_free_rdy", 32'(bus.free_rdy), 32'd0);
      free_id(3);
      check("t6_overflow", 32'(bus.free_overflow), 32'd1);
      check("t6_num_free", 32'(bus.num_free), 32'd64);
      for (int i = 0; i < 3; i++) tick();
      check("t6_overflow_sticky", 32'(bus.free_overflow), 32'd1);
      for (int i = 0; i < 3; i++) request(2'b01, g, a, id, lat);
      check("t6_mid_drain", 32'(bus.num_free), 32'd61);
      do_reset(cyc);
      check("t6_reinit_cycles", 32'(cyc), 32'd64);
      check("t6_reinit_num_free", 32'(bus.num_free), 32'd64);
      check("t6_reinit_overflow", 32'(bus.free_overflow), 32'd0);

      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
